// File: rtl/bg_scroll_map.sv
// -----------------------------------------------------------------------------
// bg_scroll_map
// Pipelined background generator for the VGA pixel path. It maps each pixel
// coordinate to an RGB444 colour. Rows at or above the horizon are sky. Rows
// below the horizon show a two-colour checkered ground. The ground scrolls
// horizontally by an offset that is updated once per frame.
//
// Optional feature macro: BG_PALETTE_WR_EN
//   Defined   : adds run-time writable palette registers (pal_we/pal_sel/pal_data).
//   Undefined : colours are the parameter constants.
//
// Ports
//   clock        in   1    pixel clock, rising edge
//   reset        in   1    synchronous, active-high
//   x            in   X_W  pixel column, sampled when pix_valid=1
//   y            in   Y_W  pixel row, sampled when pix_valid=1
//   pix_valid    in   1    x/y belong to the active area
//   frame_start  in   1    one-cycle pulse per frame
//   scroll_en    in   1    allow offset update at frame_start
//   scroll_step  in   8    unsigned offset increment per frame
//   pal_we       in   1    palette write strobe     (BG_PALETTE_WR_EN only)
//   pal_sel      in   2    0 sky, 1 ground, 2 alt   (BG_PALETTE_WR_EN only)
//   pal_data     in   12   new palette colour       (BG_PALETTE_WR_EN only)
//   out          out  12   {r[3:0],g[3:0],b[3:0]}
//   out_valid    out  1    out belongs to an active pixel
//
// Latency: a sample taken at edge N appears on out/out_valid after edge N+2.
// -----------------------------------------------------------------------------
module bg_scroll_map #(
  parameter int          X_W       = 12,
  parameter int          Y_W       = 11,
  parameter int          GROUND_Y  = 700,
  parameter int          TILE_LOG2 = 4,
  parameter logic [11:0] SKY_COLOR = 12'h000,
  parameter logic [11:0] GND_COLOR = 12'h681,
  parameter logic [11:0] GND_ALT   = 12'h570
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           pix_valid,
  input  logic           frame_start,
  input  logic           scroll_en,
  input  logic [7:0]     scroll_step,
`ifdef BG_PALETTE_WR_EN
  input  logic           pal_we,
  input  logic [1:0]     pal_sel,
  input  logic [11:0]    pal_data,
`endif
  output logic [11:0]    out,
  output logic           out_valid
);

  // Checker parity: tiles alternate on the TILE_LOG2 bit of both axes.
  function automatic logic tile_par(input logic [X_W-1:0] sx, input logic [Y_W-1:0] yy);
    return sx[TILE_LOG2] ^ yy[TILE_LOG2];
  endfunction

  logic [X_W-1:0] scroll_off_r;
  logic [X_W-1:0] sx_r;
  logic [Y_W-1:0] y0_r;
  logic           v0_r;
  logic [11:0]    col1_r;
  logic           v1_r;

  logic [11:0]    sky_s;
  logic [11:0]    gnd_s;
  logic [11:0]    alt_s;
  logic [11:0]    col_s;
  logic           is_gnd_s;
  logic           par_s;

`ifdef BG_PALETTE_WR_EN
  logic [11:0] pal_sky_r;
  logic [11:0] pal_gnd_r;
  logic [11:0] pal_alt_r;

  // Palette registers; a write is seen by the stage-1 lookup one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      pal_sky_r <= SKY_COLOR;
      pal_gnd_r <= GND_COLOR;
      pal_alt_r <= GND_ALT;
    end else if (pal_we) begin
      case (pal_sel)
        2'd0:    pal_sky_r <= pal_data;
        2'd1:    pal_gnd_r <= pal_data;
        2'd2:    pal_alt_r <= pal_data;
        default: ; // selector 3 is reserved and ignored
      endcase
    end
  end

  assign sky_s = pal_sky_r;
  assign gnd_s = pal_gnd_r;
  assign alt_s = pal_alt_r;
`else
  assign sky_s = SKY_COLOR;
  assign gnd_s = GND_COLOR;
  assign alt_s = GND_ALT;
`endif

  // Per-frame scroll offset; the sample on the same edge still sees the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      scroll_off_r <= {X_W{1'b0}};
    end else if (frame_start && scroll_en) begin
      scroll_off_r <= scroll_off_r + {{(X_W-8){1'b0}}, scroll_step};
    end
  end

  // Stage 0: capture the scrolled column (wraps mod 2**X_W), the row and valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      sx_r <= {X_W{1'b0}};
      y0_r <= {Y_W{1'b0}};
      v0_r <= 1'b0;
    end else begin
      sx_r <= x + scroll_off_r;
      y0_r <= y;
      v0_r <= pix_valid;
    end
  end

  // Stage 1 colour select; blanked samples are forced to black.
  always_comb begin
    is_gnd_s = (y0_r > Y_W'(GROUND_Y));
    par_s    = tile_par(sx_r, y0_r);
    col_s    = 12'h000;
    if (!v0_r) begin
      col_s = 12'h000;
    end else if (!is_gnd_s) begin
      col_s = sky_s;
    end else if (par_s) begin
      col_s = alt_s;
    end else begin
      col_s = gnd_s;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clock) begin
    if (reset) begin
      col1_r <= 12'h000;
      v1_r   <= 1'b0;
    end else begin
      col1_r <= col_s;
      v1_r   <= v0_r;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      out       <= 12'h000;
      out_valid <= 1'b0;
    end else begin
      out       <= col1_r;
      out_valid <= v1_r;
    end
  end

endmodule

// File: tb/tb_bg_scroll_map.sv
// -----------------------------------------------------------------------------
// tb_bg_scroll_map
// Directed plus short random stimulus for bg_scroll_map. Each driven sample
// pushes its expected {valid,colour} into a queue; two edges later the DUT
// output is compared against the popped entry.
// -----------------------------------------------------------------------------
module tb_bg_scroll_map;

  localparam int GROUND_Y = 700;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] x;
  logic [10:0] y;
  logic        pix_valid;
  logic        frame_start;
  logic        scroll_en;
  logic [7:0]  scroll_step;
  logic [11:0] out;
  logic        out_valid;
`ifdef BG_PALETTE_WR_EN
  logic        pal_we;
  logic [1:0]  pal_sel;
  logic [11:0] pal_data;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [12:0] exp_q[$];
  int          m_off;
  logic [11:0] m_sky, m_gnd, m_alt;

  bg_scroll_map dut (
    .clock       (clock),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .scroll_step (scroll_step),
`ifdef BG_PALETTE_WR_EN
    .pal_we      (pal_we),
    .pal_sel     (pal_sel),
    .pal_data    (pal_data),
`endif
    .out         (out),
    .out_valid   (out_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] model_color(input int xi, input int yi, input int off);
    int sx;
    int par;
    sx  = (xi + off) % 4096;
    par = ((sx / 16) % 2) ^ ((yi / 16) % 2);
    if (yi <= GROUND_Y) return m_sky;
    if (par != 0)       return m_alt;
    return m_gnd;
  endfunction

  task automatic check_out(input string tag);
    logic [12:0] e;
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
    end else begin
      e = 13'h0000;  // pipeline still empty after reset
    end
    checks++;
    assert (out_valid === e[12]) else begin
      errors++;
      $error("FAIL %s valid: got %b expected %b", tag, out_valid, e[12]);
    end
    checks++;
    assert (out === e[11:0]) else begin
      errors++;
      $error("FAIL %s colour: got %h expected %h", tag, out, e[11:0]);
    end
  endtask

  // Drive one sample at the negedge, advance one cycle, check at next negedge.
  task automatic step(input string tag, input int xi, input int yi, input bit pv,
                      input bit fs, input bit se, input int st);
    x           = xi[11:0];
    y           = yi[10:0];
    pix_valid   = pv;
    frame_start = fs;
    scroll_en   = se;
    scroll_step = st[7:0];
`ifdef BG_PALETTE_WR_EN
    if (pal_we) begin
      case (pal_sel)
        2'd0:    m_sky = pal_data;
        2'd1:    m_gnd = pal_data;
        2'd2:    m_alt = pal_data;
        default: ;
      endcase
    end
`endif
    if (pv) exp_q.push_back({1'b1, model_color(xi % 4096, yi % 2048, m_off)});
    else    exp_q.push_back(13'h0000);
    if (fs && se) m_off = (m_off + (st % 256)) % 4096;
    @(posedge clock);
    @(negedge clock);
    check_out(tag);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      exp_q.delete();
      check_out("reset");
    end
    m_off = 0;
    m_sky = 12'h000;
    m_gnd = 12'h681;
    m_alt = 12'h570;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; pix_valid = 1'b0;
    frame_start = 1'b0; scroll_en = 1'b0; scroll_step = '0;
`ifdef BG_PALETTE_WR_EN
    pal_we = 1'b0; pal_sel = 2'd0; pal_data = 12'h000;
`endif
    m_off = 0; m_sky = 12'h000; m_gnd = 12'h681; m_alt = 12'h570;
    @(negedge clock);
    do_reset(3);

    // Latency, horizon boundary, tile parity
    step("first",   0,   0, 1, 0, 0, 0);
    step("y700",    0, 700, 1, 0, 0, 0);
    step("y701",    0, 701, 1, 0, 0, 0);
    step("x16",    16, 701, 1, 0, 0, 0);
    step("x32",    32, 720, 1, 0, 0, 0);
    step("y716",    0, 716, 1, 0, 0, 0);

    // Offset 1, then x wraps around
    step("fs1",     0,   0, 0, 1, 1, 1);
    step("wrap0", 4095, 701, 1, 0, 0, 0);
    step("wrap1", 4094, 701, 1, 0, 0, 0);

    // Frame start coincident with a valid sample uses the old offset
    step("coinc",   0, 701, 1, 1, 1, 16);
    step("newoff",  0, 701, 1, 0, 0, 0);

    // Reset mid-stream flushes the pipeline and clears the offset
    do_reset(2);
    step("hold",    0, 701, 1, 1, 0, 16);
    step("held",    0, 701, 1, 0, 0, 0);
    step("scroll",  0,   0, 0, 1, 1, 16);
    step("scrolled",0, 701, 1, 0, 0, 0);

    // Blanking toggles
    step("pv1",     5, 800, 1, 0, 0, 0);
    step("pv0",     5, 800, 0, 0, 0, 0);
    step("pv1b",   21, 800, 1, 0, 0, 0);

    // Large steps that wrap the offset
    for (int i = 0; i < 20; i++) step("big", 100, 900, 1, 1, 1, 255);

    // Random traffic
    for (int i = 0; i < 60; i++)
      step("rand", $urandom_range(0, 4095), $urandom_range(650, 1000),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 255));

`ifdef BG_PALETTE_WR_EN
    pal_we = 1'b1; pal_sel = 2'd1; pal_data = 12'hF00;
    step("palw",    0,   0, 0, 0, 0, 0);
    pal_we = 1'b1; pal_sel = 2'd3; pal_data = 12'h0F0;
    step("pal3",    0,   0, 0, 0, 0, 0);
    pal_we = 1'b0;
    for (int i = 0; i < 8; i++) step("palrd", i * 16, 701 + i * 16, 1, 0, 0, 0);
    pal_we = 1'b1; pal_sel = 2'd0; pal_data = 12'h00F;
    step("palsky",  0, 100, 1, 0, 0, 0);
    pal_we = 1'b0;
    step("palsky2", 0, 100, 1, 0, 0, 0);
`endif

    // Drain
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
